// File: rtl/bram_asym_fifo_pkg.sv
// Shared widths and helpers for the asymmetric (narrow-write, wide-read) BRAM FIFO.
// Pointer-derived fill arithmetic lives here so the top and any future variants agree.
package bram_asym_fifo_pkg;

  localparam int WR_WIDTH_DEF   = 8;
  localparam int RATIO_LOG2_DEF = 2;
  localparam int RD_AW_DEF      = 10;

  function automatic int ratio_f(input int ratio_log2);
    return 32'sd1 <<< ratio_log2;
  endfunction

  function automatic int wr_aw_f(input int rd_aw, input int ratio_log2);
    return rd_aw + ratio_log2;
  endfunction

  function automatic int depth_n_f(input int rd_aw, input int ratio_log2);
    return 32'sd1 <<< (rd_aw + ratio_log2);
  endfunction

  // Narrow entries held; the wide read pointer is scaled up to narrow units first.
  function automatic logic [31:0] fill_f(input logic [31:0] wr_ptr,
                                         input logic [31:0] rd_ptr,
                                         input int          ratio_log2,
                                         input int          wr_aw);
    logic [31:0] mask_v;
    mask_v = (32'd1 << (wr_aw + 1)) - 32'd1;
    return (wr_ptr - (rd_ptr << ratio_log2)) & mask_v;
  endfunction

endpackage

// File: rtl/sdpram_8x4096_32x1024.sv
// Simple dual-port storage: narrow write port, registered wide read port.
// Laid out as RATIO byte lanes per wide word so synthesis infers one asymmetric BRAM.
module sdpram_8x4096_32x1024
  import bram_asym_fifo_pkg::*;
#(
  parameter int WR_WIDTH   = WR_WIDTH_DEF,
  parameter int RATIO_LOG2 = RATIO_LOG2_DEF,
  parameter int RD_AW      = RD_AW_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   we,
  input  logic [RD_AW+RATIO_LOG2-1:0]            waddr,
  input  logic [WR_WIDTH-1:0]                    wdata,
  input  logic                                   re,
  input  logic [RD_AW-1:0]                       raddr,
  output logic [WR_WIDTH*(2**RATIO_LOG2)-1:0]    rdata
);

  localparam int RATIO = ratio_f(RATIO_LOG2);
  localparam int WR_AW = wr_aw_f(RD_AW, RATIO_LOG2);
  localparam int WORDS = 2 ** RD_AW;

  logic [RATIO-1:0][WR_WIDTH-1:0] mem_r [WORDS];
  logic [WR_WIDTH*RATIO-1:0]      rdata_r;

  // Narrow write into one byte lane of the addressed wide word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr[WR_AW-1:RATIO_LOG2]][waddr[RATIO_LOG2-1:0]] <= wdata;
    end
  end

  // Registered wide read; output register holds between reads and clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/bram_fifo_narrow_wr_wide_rd.sv
// Byte-in, word-out synchronous FIFO on one asymmetric BRAM; lowest byte lands in the LSBs.
// Define BRAM_ASYM_FIFO_LEVEL_EN to add the rd_level / wr_free occupancy ports.
module bram_fifo_narrow_wr_wide_rd
  import bram_asym_fifo_pkg::*;
#(
  parameter int WR_WIDTH   = WR_WIDTH_DEF,
  parameter int RATIO_LOG2 = RATIO_LOG2_DEF,
  parameter int RD_AW      = RD_AW_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [WR_WIDTH-1:0]                 wr_data,
  output logic                                full,
  output logic                                overflow,
  input  logic                                rd_en,
  output logic [WR_WIDTH*(2**RATIO_LOG2)-1:0] rd_data,
  output logic                                rd_valid,
  output logic                                empty,
  output logic                                underflow
`ifdef BRAM_ASYM_FIFO_LEVEL_EN
  ,
  output logic [RD_AW:0]                      rd_level,
  output logic [RD_AW+RATIO_LOG2:0]           wr_free
`endif
);

  localparam int RATIO   = ratio_f(RATIO_LOG2);
  localparam int WR_AW   = wr_aw_f(RD_AW, RATIO_LOG2);
  localparam int DEPTH_N = depth_n_f(RD_AW, RATIO_LOG2);

  localparam logic [WR_AW:0] DEPTH_V  = DEPTH_N[WR_AW:0];
  localparam logic [WR_AW:0] RATIO_V  = RATIO[WR_AW:0];
  localparam logic [WR_AW:0] WR_ONE_V = {{WR_AW{1'b0}}, 1'b1};
  localparam logic [RD_AW:0] RD_ONE_V = {{RD_AW{1'b0}}, 1'b1};

  logic [WR_AW:0] wr_ptr_r;
  logic [RD_AW:0] rd_ptr_r;
  logic           overflow_r;
  logic           underflow_r;
  logic           rd_valid_r;

  logic [31:0]    fill_w_s;
  logic [WR_AW:0] fill_s;
  logic           unused_fill_s;
  logic           full_s;
  logic           empty_s;
  logic           wr_acc_s;
  logic           rd_acc_s;

  assign fill_w_s      = fill_f(32'(wr_ptr_r), 32'(rd_ptr_r), RATIO_LOG2, WR_AW);
  assign fill_s        = fill_w_s[WR_AW:0];
  assign unused_fill_s = ^fill_w_s[31:WR_AW+1];

  // Flags come from pre-edge pointers, so a read never frees space for a same-cycle write.
  assign full_s   = (fill_s == DEPTH_V);
  assign empty_s  = (fill_s < RATIO_V);
  assign wr_acc_s = wr_en && !full_s;
  assign rd_acc_s = rd_en && !empty_s;

  // Write pointer in narrow units, with wrap bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
    end else if (wr_acc_s) begin
      wr_ptr_r <= wr_ptr_r + WR_ONE_V;
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer in wide units, with wrap bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= '0;
    end else if (rd_acc_s) begin
      rd_ptr_r <= rd_ptr_r + RD_ONE_V;
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Read-valid pulse and sticky misuse flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      rd_valid_r  <= rd_acc_s;
      overflow_r  <= overflow_r  | (wr_en && full_s);
      underflow_r <= underflow_r | (rd_en && empty_s);
    end
  end

  sdpram_8x4096_32x1024 #(
    .WR_WIDTH   (WR_WIDTH),
    .RATIO_LOG2 (RATIO_LOG2),
    .RD_AW      (RD_AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r[WR_AW-1:0]),
    .wdata (wr_data),
    .re    (rd_acc_s),
    .raddr (rd_ptr_r[RD_AW-1:0]),
    .rdata (rd_data)
  );

  assign full      = full_s;
  assign empty     = empty_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign rd_valid  = rd_valid_r;

`ifdef BRAM_ASYM_FIFO_LEVEL_EN
  assign rd_level = fill_s[WR_AW:RATIO_LOG2];
  assign wr_free  = DEPTH_V - fill_s;
`endif

endmodule
